// File: rtl/shared_mem_pkg.sv
// Shared types and constants for the dual-core shared data-memory controller.
package shared_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic core_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_grant only advances when the update enable is pulsed.
module rr_arbiter2
  import shared_mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic [1:0] req,
  input  logic     upd,
  output core_id_t gnt
);

  core_id_t last_q;

  always_comb begin
    gnt = 1'b0;
    if (req[0] && req[1]) begin
      gnt = ~last_q;
    end else if (req[1]) begin
      gnt = 1'b1;
    end
  end

  // Reset to core 1 so that core 0 wins the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/shared_dmem_ctrl.sv
// Shared word-organised data RAM serving two cores through a round-robin arbitrated
// IDLE -> ACCESS -> RESP access sequence with byte/half/word load/store.
module shared_dmem_ctrl
  import shared_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ACCESS_LAT  = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic [2:0]  c0_funct3,
  input  logic        c0_read,
  input  logic        c0_write,
  output logic [31:0] c0_rdata,
  output logic        c0_ready,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  input  logic [2:0]  c1_funct3,
  input  logic        c1_read,
  input  logic        c1_write,
  output logic [31:0] c1_rdata,
  output logic        c1_ready
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_LAT - 1);

  logic [31:0] ram [DEPTH_WORDS];

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       f3_q;
  logic             wr_q;
  core_id_t         gnt_q;
  logic [31:0]      rdata_q [2];

  logic [1:0] req;
  logic       upd;
  logic       latch;
  logic       last_access;
  core_id_t   gnt;

  assign req = {c1_read | c1_write, c0_read | c0_write};
  assign upd = (state_q == IDLE) && req[0] && req[1];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .upd   (upd),
    .gnt   (gnt)
  );

  logic unused_addr_hi;
  assign unused_addr_hi = ^{c0_addr[31:IDX_W+2], c1_addr[31:IDX_W+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          latch   = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign last_access = (state_q == ACCESS) && (cnt_q == CNT_LAST);

  logic [IDX_W-1:0] idx_q;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_data;

  assign idx_q   = addr_q[IDX_W+1:2];
  assign rd_word = ram[idx_q];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    unique case (f3_q)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_BU:   load_data = {24'h0, rd_byte};
      F3_HU:   load_data = {16'h0, rd_half};
      F3_W:    load_data = rd_word;
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes; the byte-enable mask picks the written lanes.
  logic [31:0] st_lanes;
  logic [3:0]  st_be;
  logic [31:0] st_mask;

  always_comb begin
    st_lanes = wdata_q;
    st_be    = 4'b1111;
    unique case (f3_q)
      F3_B: begin
        st_lanes = {4{wdata_q[7:0]}};
        st_be    = 4'b0001 << addr_q[1:0];
      end
      F3_H: begin
        st_lanes = {2{wdata_q[15:0]}};
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_lanes = wdata_q;
        st_be    = 4'b1111;
      end
    endcase
  end

  assign st_mask = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      wr_q       <= 1'b0;
      gnt_q      <= 1'b0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q  <= gnt ? c1_addr[IDX_W+1:0] : c0_addr[IDX_W+1:0];
        wdata_q <= gnt ? c1_wdata : c0_wdata;
        f3_q    <= gnt ? c1_funct3 : c0_funct3;
        wr_q    <= gnt ? c1_write : c0_write;
        gnt_q   <= gnt;
      end
      if (last_access) begin
        rdata_q[gnt_q] <= wr_q ? 32'h0 : load_data;
      end
    end
  end

  // Store commits at the edge ending RESP; an async reset leaves RESP before that edge.
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == RESP) && wr_q) begin
      ram[idx_q] <= (rd_word & ~st_mask) | (st_lanes & st_mask);
    end
  end

  assign c0_ready = rst_n && (!req[0] || ((state_q == RESP) && (gnt_q == 1'b0)));
  assign c1_ready = rst_n && (!req[1] || ((state_q == RESP) && (gnt_q == 1'b1)));
  assign c0_rdata = rdata_q[0];
  assign c1_rdata = rdata_q[1];

endmodule
